// File: rtl/elevator_pkg.sv
// Shared floor encoding, controller state/direction types and the SCAN decision helper.
package elevator_pkg;

   localparam int unsigned FLOOR_W = 2;
   localparam int unsigned NFLOORS = 3;

   localparam logic [FLOOR_W-1:0] FLOOR_0 = 2'b00;
   localparam logic [FLOOR_W-1:0] FLOOR_1 = 2'b01;
   localparam logic [FLOOR_W-1:0] FLOOR_2 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MOVE_UP = 2'd1,
      ST_MOVE_DN = 2'd2,
      ST_DOOR    = 2'd3
   } fsm_e;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_e;

   typedef struct packed {
      fsm_e nxt;
      dir_e dir;
   } decision_t;

   function automatic logic [NFLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
      logic [NFLOORS-1:0] m;
      m = '0;
      case (f)
         FLOOR_0: m = 3'b110;
         FLOOR_1: m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic logic [NFLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
      logic [NFLOORS-1:0] m;
      m = '0;
      case (f)
         FLOOR_1: m = 3'b001;
         FLOOR_2: m = 3'b011;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   // Serve here first, else keep going the current way, else reverse, else rest.
   function automatic decision_t decide(input logic [FLOOR_W-1:0] f,
                                        input dir_e               d,
                                        input logic [NFLOORS-1:0] req,
                                        input logic               from_idle);
      decision_t          r;
      logic [NFLOORS-1:0] up_req;
      logic [NFLOORS-1:0] dn_req;
      up_req = req & above_mask(f);
      dn_req = req & below_mask(f);
      r.nxt  = ST_IDLE;
      r.dir  = d;
      if (req[f]) begin
         r.nxt = ST_DOOR;
      end else if (from_idle && (|up_req) && (|dn_req)) begin
         r.nxt = ST_MOVE_UP;
         r.dir = DIR_UP;
      end else if (d == DIR_UP) begin
         if (|up_req) begin
            r.nxt = ST_MOVE_UP;
         end else if (|dn_req) begin
            r.nxt = ST_MOVE_DN;
            r.dir = DIR_DN;
         end
      end else begin
         if (|dn_req) begin
            r.nxt = ST_MOVE_DN;
         end else if (|up_req) begin
            r.nxt = ST_MOVE_UP;
            r.dir = DIR_UP;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by door dwell and floor travel; done while count is zero.
module elevator_timer #(
   parameter int unsigned TMR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             done
);

   logic [TMR_W-1:0] count_q;
   logic [TMR_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Three-floor elevator controller: latches hall requests, moves floor-by-floor with SCAN,
// and holds the door open for a counted dwell at each served floor.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int unsigned DOOR_CYCLES   = 4,
   parameter int unsigned TRAVEL_CYCLES = 8,
   parameter int unsigned TMR_W         = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               st_button,
   input  logic               nd_button,
   input  logic               rd_button,
   output logic [FLOOR_W-1:0] state,
   output logic               open_door,
   output logic               moving_up,
   output logic               moving_down,
   output logic [NFLOORS-1:0] pending
);

   logic [FLOOR_W-1:0] floor_q, floor_d;
   fsm_e               fsm_q, fsm_d;
   dir_e               dir_q, dir_d;
   logic [NFLOORS-1:0] pending_q, pending_d;
   logic               open_door_q, open_door_d;
   logic               moving_up_q, moving_up_d;
   logic               moving_down_q, moving_down_d;

   logic [NFLOORS-1:0] btn;
   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_val;
   logic               tmr_done;

   logic               eval;
   logic               eval_idle;
   logic [FLOOR_W-1:0] eval_floor;
   logic [NFLOORS-1:0] eval_req;
   decision_t          dec;

   assign btn = {rd_button, nd_button, st_button};

   elevator_timer #(
      .TMR_W(TMR_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .load_val(tmr_val),
      .done    (tmr_done)
   );

   // Next state: request latching, decision points (idle, arrival, dwell end), timer control.
   always_comb begin
      floor_d    = floor_q;
      fsm_d      = fsm_q;
      dir_d      = dir_q;
      pending_d  = pending_q | btn;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      eval       = 1'b0;
      eval_idle  = 1'b0;
      eval_floor = floor_q;
      eval_req   = pending_q;

      case (fsm_q)
         ST_IDLE: begin
            eval      = 1'b1;
            eval_idle = 1'b1;
         end
         ST_DOOR: begin
            // A press for the floor we are standing at only extends the dwell.
            if (btn[floor_q]) begin
               pending_d[floor_q] = pending_q[floor_q];
               tmr_load           = 1'b1;
               tmr_val            = TMR_W'(DOOR_CYCLES - 1);
            end else if (tmr_done) begin
               eval = 1'b1;
            end
         end
         ST_MOVE_UP, ST_MOVE_DN: begin
            if (tmr_done) begin
               eval       = 1'b1;
               eval_floor = (fsm_q == ST_MOVE_UP) ? floor_q + FLOOR_W'(1)
                                                  : floor_q - FLOOR_W'(1);
               eval_req   = pending_q | btn;
               floor_d    = eval_floor;
            end
         end
         default: ;
      endcase

      dec = decide(eval_floor, dir_q, eval_req, eval_idle);

      if (eval) begin
         fsm_d = dec.nxt;
         dir_d = dec.dir;
         case (dec.nxt)
            ST_DOOR: begin
               pending_d[eval_floor] = 1'b0;
               tmr_load              = 1'b1;
               tmr_val               = TMR_W'(DOOR_CYCLES - 1);
            end
            ST_MOVE_UP, ST_MOVE_DN: begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(TRAVEL_CYCLES - 1);
            end
            default: ;
         endcase
      end

      open_door_d   = (fsm_d == ST_DOOR);
      moving_up_d   = (fsm_d == ST_MOVE_UP);
      moving_down_d = (fsm_d == ST_MOVE_DN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         floor_q       <= FLOOR_0;
         fsm_q         <= ST_IDLE;
         dir_q         <= DIR_UP;
         pending_q     <= '0;
         open_door_q   <= 1'b0;
         moving_up_q   <= 1'b0;
         moving_down_q <= 1'b0;
      end else begin
         floor_q       <= floor_d;
         fsm_q         <= fsm_d;
         dir_q         <= dir_d;
         pending_q     <= pending_d;
         open_door_q   <= open_door_d;
         moving_up_q   <= moving_up_d;
         moving_down_q <= moving_down_d;
      end
   end

   assign state       = floor_q;
   assign open_door   = open_door_q;
   assign moving_up   = moving_up_q;
   assign moving_down = moving_down_q;
   assign pending     = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: behavioural car model checked every cycle, directed scenarios
// with hand-computed timings, then randomized button traffic with occasional async resets.
module tb_elevator_scheduler;

   localparam int DOOR_CYCLES   = 4;
   localparam int TRAVEL_CYCLES = 8;
   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_DOOR = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       st_button = 1'b0;
   logic       nd_button = 1'b0;
   logic       rd_button = 1'b0;
   logic [1:0] state;
   logic       open_door;
   logic       moving_up;
   logic       moving_down;
   logic [2:0] pending;

   int errors = 0;
   int checks = 0;

   // Model: floor as an integer, activity as a mode plus cycles remaining in it.
   int       m_floor = 0;
   int       m_mode  = M_IDLE;
   int       m_dir   = 1;
   int       m_left  = 0;
   bit [2:0] m_req   = 3'b000;

   elevator_scheduler #(
      .DOOR_CYCLES  (DOOR_CYCLES),
      .TRAVEL_CYCLES(TRAVEL_CYCLES),
      .TMR_W        (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .st_button  (st_button),
      .nd_button  (nd_button),
      .rd_button  (rd_button),
      .state      (state),
      .open_door  (open_door),
      .moving_up  (moving_up),
      .moving_down(moving_down),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_decide(input bit [2:0] view, input bit from_idle);
      bit above;
      bit below;
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (view[i] && i > m_floor) above = 1'b1;
         if (view[i] && i < m_floor) below = 1'b1;
      end
      if (view[m_floor]) begin
         m_mode = M_DOOR;
         m_left = DOOR_CYCLES;
         m_req[m_floor] = 1'b0;
      end else if (from_idle && above && below) begin
         m_dir  = 1;
         m_mode = M_MOVE;
         m_left = TRAVEL_CYCLES;
      end else if ((m_dir > 0 && above) || (m_dir < 0 && below)) begin
         m_mode = M_MOVE;
         m_left = TRAVEL_CYCLES;
      end else if (above || below) begin
         m_dir  = -m_dir;
         m_mode = M_MOVE;
         m_left = TRAVEL_CYCLES;
      end else begin
         m_mode = M_IDLE;
      end
   endtask

   task automatic m_step(input bit [2:0] b);
      bit [2:0] old;
      old = m_req;
      for (int i = 0; i < 3; i++) begin
         if (b[i] && !(m_mode == M_DOOR && i == m_floor)) m_req[i] = 1'b1;
      end
      case (m_mode)
         M_IDLE: m_decide(old, 1'b1);
         M_DOOR: begin
            if (b[m_floor]) m_left = DOOR_CYCLES;
            else if (m_left == 1) m_decide(old, 1'b0);
            else m_left--;
         end
         default: begin
            if (m_left == 1) begin
               m_floor = m_floor + m_dir;
               m_decide(m_req, 1'b0);
            end else begin
               m_left--;
            end
         end
      endcase
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_floor = 0;
         m_mode  = M_IDLE;
         m_dir   = 1;
         m_left  = 0;
         m_req   = 3'b000;
      end else begin
         m_step({rd_button, nd_button, st_button});
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("state", int'(state), m_floor);
      chk("open_door", int'(open_door), int'(m_mode == M_DOOR));
      chk("moving_up", int'(moving_up), int'(m_mode == M_MOVE && m_dir > 0));
      chk("moving_down", int'(moving_down), int'(m_mode == M_MOVE && m_dir < 0));
      chk("pending", int'(pending), int'(m_req));
      chk("exclusive", int'(open_door) + int'(moving_up) + int'(moving_down) <= 1 ? 1 : 0, 1);
   end

   function automatic int sig(input int w);
      case (w)
         0:       return int'(open_door);
         1:       return int'(moving_up);
         default: return int'(moving_down);
      endcase
   endfunction

   task automatic wait_sig(input int w, input int limit, output int delay);
      delay = 0;
      while (sig(w) == 0 && delay < limit) begin
         @(negedge clk);
         delay++;
      end
   endtask

   task automatic count_high(input int w, output int n);
      n = 0;
      while (sig(w) != 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic reset_dut();
      st_button = 1'b0;
      nd_button = 1'b0;
      rd_button = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"}, int'(state), 0);
      chk({tag, "_open"}, int'(open_door), 0);
      chk({tag, "_up"}, int'(moving_up), 0);
      chk({tag, "_down"}, int'(moving_down), 0);
      chk({tag, "_pending"}, int'(pending), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int d;
      int n;

      // Reset held with all buttons pressed
      st_button = 1'b1;
      nd_button = 1'b1;
      rd_button = 1'b1;
      @(negedge clk);
      chk_all_zero("s1_in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("s1_pending_after_release", int'(pending), 7);
      chk("s1_state_after_release", int'(state), 0);

      // Request at the current idle floor
      reset_dut();
      st_button = 1'b1;
      @(negedge clk);
      st_button = 1'b0;
      chk("s2_pending_latched", int'(pending), 1);
      wait_sig(0, 10, d);
      chk("s2_open_delay", d, 1);
      count_high(0, n);
      chk("s2_open_cycles", n, 4);
      chk("s2_pending_clear", int'(pending), 0);

      // Two-floor trip up without stopping at floor 1
      reset_dut();
      rd_button = 1'b1;
      @(negedge clk);
      rd_button = 1'b0;
      chk("s3_pending", int'(pending), 4);
      wait_sig(1, 10, d);
      chk("s3_depart_delay", d, 1);
      count_high(1, n);
      chk("s3_up_cycles", n, 16);
      chk("s3_arrive_state", int'(state), 2);
      count_high(0, n);
      chk("s3_open_cycles", n, 4);
      chk("s3_pending_clear", int'(pending), 0);

      // From floor 1 with requests above and below: up first, then sweep down
      reset_dut();
      nd_button = 1'b1;
      @(negedge clk);
      nd_button = 1'b0;
      repeat (20) @(negedge clk);
      chk("s4_idle_floor", int'(state), 1);
      chk("s4_idle_open", int'(open_door), 0);
      st_button = 1'b1;
      rd_button = 1'b1;
      @(negedge clk);
      st_button = 1'b0;
      rd_button = 1'b0;
      chk("s4_pending", int'(pending), 5);
      wait_sig(1, 10, d);
      chk("s4_up_delay", d, 1);
      count_high(1, n);
      chk("s4_up_cycles", n, 8);
      chk("s4_top_state", int'(state), 2);
      count_high(0, n);
      chk("s4_top_open", n, 4);
      chk("s4_reverse", int'(moving_down), 1);
      count_high(2, n);
      chk("s4_down_cycles", n, 16);
      chk("s4_bottom_state", int'(state), 0);
      count_high(0, n);
      chk("s4_bottom_open", n, 4);

      // Intermediate request picked up on the way
      reset_dut();
      rd_button = 1'b1;
      @(negedge clk);
      rd_button = 1'b0;
      @(negedge clk);
      chk("s5_departed", int'(moving_up), 1);
      repeat (2) @(negedge clk);
      nd_button = 1'b1;
      @(negedge clk);
      nd_button = 1'b0;
      count_high(1, n);
      chk("s5_first_leg", n, 5);
      chk("s5_stop_floor", int'(state), 1);
      count_high(0, n);
      chk("s5_mid_open", n, 4);
      chk("s5_resume", int'(moving_up), 1);
      count_high(1, n);
      chk("s5_second_leg", n, 8);
      chk("s5_final_floor", int'(state), 2);
      count_high(0, n);
      chk("s5_final_open", n, 4);

      // Dwell restart at floor 1, then async reset while moving
      reset_dut();
      nd_button = 1'b1;
      @(negedge clk);
      nd_button = 1'b0;
      wait_sig(0, 20, d);
      chk("s6_open_delay", d, 9);
      chk("s6_floor", int'(state), 1);
      @(negedge clk);
      nd_button = 1'b1;
      @(negedge clk);
      @(negedge clk);
      nd_button = 1'b0;
      chk("s6_pending_not_latched", int'(pending), 0);
      count_high(0, n);
      chk("s6_restarted_open", n, 4);
      rd_button = 1'b1;
      @(negedge clk);
      rd_button = 1'b0;
      wait_sig(1, 10, d);
      chk("s6_depart_delay", d, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("s6_async_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic with held levels and rare mid-cycle resets
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) st_button = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) nd_button = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) rd_button = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            #1 chk_all_zero("rnd_async_reset");
            #1 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      st_button = 1'b0;
      nd_button = 1'b0;
      rd_button = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
